// File: rtl/mbc_pkg.sv
// mbc_pkg: shared types, register-region decode and reset values for the MBC.
// Used by mbc_wr_filter and mbc_sync.
package mbc_pkg;

    typedef enum logic [1:0] {
        WF_IDLE,
        WF_LOW,
        WF_ARMED,
        WF_COMMIT
    } wf_state_e;

    typedef enum logic [2:0] {
        RG_RAM_EN,
        RG_ROM_LO,
        RG_ROM_HI,
        RG_RAM_BANK,
        RG_NONE
    } reg_region_e;

    localparam logic [2:0] A_RAM_EN   = 3'b000;
    localparam logic [3:0] A_ROM_LO   = 4'b0010;
    localparam logic [3:0] A_ROM_HI   = 4'b0011;
    localparam logic [2:0] A_RAM_BANK = 3'b010;
    localparam logic [3:0] RAM_EN_KEY = 4'hA;

    localparam logic [8:0] ROM_BANK_RST = 9'd1;
    localparam logic [3:0] RAM_BANK_RST = 4'd0;

    function automatic reg_region_e reg_region(input logic [3:0] a);
        reg_region_e r;
        r = RG_NONE;
        unique case (1'b1)
            (a[3:1] == A_RAM_EN):   r = RG_RAM_EN;
            (a == A_ROM_LO):        r = RG_ROM_LO;
            (a == A_ROM_HI):        r = RG_ROM_HI;
            (a[3:1] == A_RAM_BANK): r = RG_RAM_BANK;
            default:                r = RG_NONE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mbc_wr_filter.sv
// mbc_wr_filter: synchronises the cartridge write strobe/addr/data and
// filters short low pulses, emitting one commit per accepted write.
module mbc_wr_filter
    import mbc_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_LOW     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] gb_addr,
    input  logic [7:0] gb_data,
    input  logic       gb_write_n,
    output logic       upd,
    output logic       wr_commit,
    output logic [3:0] cap_addr,
    output logic [7:0] cap_data
);

    logic [SYNC_STAGES-1:0]      wn_s;
    logic [SYNC_STAGES-1:0]      vld_s;
    logic [SYNC_STAGES-1:0][3:0] addr_s;
    logic [SYNC_STAGES-1:0][7:0] data_s;

    logic       wn;
    logic       live;
    logic       seen_high;
    logic [2:0] cnt;
    wf_state_e  state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wn_s   <= '1;
            vld_s  <= '0;
            addr_s <= '0;
            data_s <= '0;
        end else begin
            wn_s   <= {wn_s[SYNC_STAGES-2:0], gb_write_n};
            vld_s  <= {vld_s[SYNC_STAGES-2:0], 1'b1};
            addr_s <= {addr_s[SYNC_STAGES-2:0], gb_addr};
            data_s <= {data_s[SYNC_STAGES-2:0], gb_data};
        end
    end

    assign wn   = wn_s[SYNC_STAGES-1];
    // Reset preloads the chain with 1s; only trust it once real samples arrive
    assign live = vld_s[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_high <= 1'b0;
        end else if (live && wn) begin
            seen_high <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= WF_IDLE;
            cnt       <= 3'd0;
            cap_addr  <= 4'd0;
            cap_data  <= 8'd0;
            wr_commit <= 1'b0;
        end else begin
            wr_commit <= 1'b0;
            case (state)
                WF_IDLE: begin
                    if (seen_high && !wn) begin
                        cap_addr <= addr_s[SYNC_STAGES-1];
                        cap_data <= data_s[SYNC_STAGES-1];
                        cnt      <= 3'd1;
                        state    <= (MIN_LOW == 1) ? WF_ARMED : WF_LOW;
                    end
                end
                WF_LOW: begin
                    if (wn) begin
                        cnt   <= 3'd0;
                        state <= WF_IDLE;
                    end else begin
                        cnt <= cnt + 3'd1;
                        if (cnt + 3'd1 == 3'(MIN_LOW)) begin
                            state <= WF_ARMED;
                        end
                    end
                end
                WF_ARMED: begin
                    if (wn) begin
                        state     <= WF_COMMIT;
                        wr_commit <= 1'b1;
                    end
                end
                default: begin
                    cnt   <= 3'd0;
                    state <= WF_IDLE;
                end
            endcase
        end
    end

    // Registers load on the same edge that enters COMMIT
    assign upd = (state == WF_ARMED) && wn;

endmodule

// File: rtl/mbc_sync.sv
// mbc_sync: MBC bank registers, write decode and chip selects.
// Define MBC_BANK0_REMAP_EN to store bank 1 when a write would select bank 0.
module mbc_sync
    import mbc_pkg::*;
#(
    parameter int ROM_BANK_W  = 9,
    parameter int RAM_BANK_W  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_LOW     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            gb_addr,
    input  logic [7:0]            gb_data,
    input  logic                  gb_write_n,
    input  logic                  gb_read_n,
    input  logic                  cs_n,
    output logic [ROM_BANK_W-1:0] rom_bank,
    output logic [RAM_BANK_W-1:0] ram_bank,
    output logic                  rom_cs_n,
    output logic                  ram_cs,
    output logic                  ram_cs_n,
    output logic                  wr_commit
);

    logic       upd;
    logic [3:0] cap_addr;
    logic [7:0] cap_data;

    logic [ROM_BANK_W-1:0] rom_q;
    logic [ROM_BANK_W-1:0] rom_new;
    logic [RAM_BANK_W-1:0] ram_q;
    logic [RAM_BANK_W-1:0] ram_new;
    logic                  ram_en;
    logic                  ram_en_new;
    logic [8:0]            rom_ext;

    mbc_wr_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .MIN_LOW     (MIN_LOW)
    ) u_wr_filter (
        .clk        (clk),
        .rst_n      (rst_n),
        .gb_addr    (gb_addr),
        .gb_data    (gb_data),
        .gb_write_n (gb_write_n),
        .upd        (upd),
        .wr_commit  (wr_commit),
        .cap_addr   (cap_addr),
        .cap_data   (cap_data)
    );

    always_comb begin
        rom_ext                 = '0;
        rom_ext[ROM_BANK_W-1:0] = rom_q;
        ram_new                 = ram_q;
        ram_en_new              = ram_en;
        case (reg_region(cap_addr))
            RG_RAM_EN:   ram_en_new = (cap_data[3:0] == RAM_EN_KEY);
            RG_ROM_LO:   rom_ext[7:0] = cap_data;
            RG_ROM_HI:   rom_ext[8] = cap_data[0];
            RG_RAM_BANK: ram_new = cap_data[RAM_BANK_W-1:0];
            default:     ;
        endcase
        // Narrow ROM registers drop bit 8 here, so high-bit writes vanish
        rom_new = rom_ext[ROM_BANK_W-1:0];
`ifdef MBC_BANK0_REMAP_EN
        if (rom_new == '0) begin
            rom_new = {{(ROM_BANK_W-1){1'b0}}, 1'b1};
        end
`else
        rom_new = rom_new;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_q  <= ROM_BANK_RST[ROM_BANK_W-1:0];
            ram_q  <= RAM_BANK_RST[RAM_BANK_W-1:0];
            ram_en <= 1'b0;
        end else if (upd) begin
            rom_q  <= rom_new;
            ram_q  <= ram_new;
            ram_en <= ram_en_new;
        end
    end

    assign rom_bank = gb_addr[2] ? rom_q : '0;
    assign ram_bank = ram_q;
    assign ram_cs   = ~cs_n & ~gb_addr[2] & gb_addr[1] & ram_en;
    assign ram_cs_n = ~ram_cs;
    assign rom_cs_n = ~((~gb_addr[3] & ~gb_read_n) | ~rst_n);

endmodule

// File: tb/tb_mbc_sync.sv
// tb_mbc_sync: randomized writes/reads against a transaction-level MBC model.
// Directed literal checks pin the model for the key scenarios.
module tb_mbc_sync;

    localparam int S  = 2;
    localparam int ML = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] gb_addr;
    logic [7:0] gb_data;
    logic       gb_write_n;
    logic       gb_read_n;
    logic       cs_n;
    logic [8:0] rom_bank;
    logic [3:0] ram_bank;
    logic       rom_cs_n;
    logic       ram_cs;
    logic       ram_cs_n;
    logic       wr_commit;

    mbc_sync #(
        .ROM_BANK_W  (9),
        .RAM_BANK_W  (4),
        .SYNC_STAGES (S),
        .MIN_LOW     (ML)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .gb_addr    (gb_addr),
        .gb_data    (gb_data),
        .gb_write_n (gb_write_n),
        .gb_read_n  (gb_read_n),
        .cs_n       (cs_n),
        .rom_bank   (rom_bank),
        .ram_bank   (ram_bank),
        .rom_cs_n   (rom_cs_n),
        .ram_cs     (ram_cs),
        .ram_cs_n   (ram_cs_n),
        .wr_commit  (wr_commit)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;
    int n_commit = 0;
    int exp_commits = 0;
    bit settled = 1'b0;

    logic [8:0] m_rom;
    logic [3:0] m_ram;
    logic       m_en;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function void model_reset();
        m_rom = 9'd1;
        m_ram = 4'd0;
        m_en  = 1'b0;
    endfunction

    function void model_write(input logic [3:0] a, input logic [7:0] d);
        if (a[3:1] == 3'b000)      m_en = (d[3:0] == 4'hA);
        else if (a == 4'h2)        m_rom[7:0] = d;
        else if (a == 4'h3)        m_rom[8] = d[0];
        else if (a[3:1] == 3'b010) m_ram = d[3:0];
`ifdef MBC_BANK0_REMAP_EN
        if (m_rom == 9'd0) m_rom = 9'd1;
`endif
    endfunction

    function logic exp_rom_cs_n();
        return !((!gb_addr[3] && !gb_read_n) || !rst_n);
    endfunction

    function logic exp_ram_cs();
        return !cs_n && !gb_addr[2] && gb_addr[1] && m_en;
    endfunction

    always @(posedge clk) begin
        #2;
        if (wr_commit === 1'b1) n_commit++;
        chk("rom_cs_n", rom_cs_n, exp_rom_cs_n());
        if (settled) begin
            chk("rom_bank", rom_bank, gb_addr[2] ? m_rom : 9'd0);
            chk("ram_bank", ram_bank, m_ram);
            chk("ram_cs", ram_cs, exp_ram_cs());
            chk("ram_cs_n", ram_cs_n, !exp_ram_cs());
            chk("wr_commit_idle", wr_commit, 0);
        end
    end

    task automatic do_write(input logic [3:0] a, input logic [7:0] d,
                            input int len, input logic rd);
        int lat;
        bit seen;
        @(negedge clk);
        settled    = 1'b0;
        gb_addr    = a;
        gb_data    = d;
        gb_read_n  = rd;
        gb_write_n = 1'b0;
        repeat (len) @(negedge clk);
        gb_write_n = 1'b1;
        if (len >= ML) begin
            lat  = 0;
            seen = 1'b0;
            while (!seen && lat < 12) begin
                @(posedge clk);
                #1;
                lat++;
                if (wr_commit === 1'b1) seen = 1'b1;
            end
            chk("commit_latency", lat, S + 1);
            model_write(a, d);
            exp_commits++;
        end
        repeat (S + 4) @(negedge clk);
        gb_read_n = 1'b1;
        settled   = 1'b1;
    endtask

    task automatic set_bus(input logic [3:0] a, input logic c);
        @(negedge clk);
        gb_addr = a;
        cs_n    = c;
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c0;
        rst_n      = 1'b0;
        gb_addr    = 4'h0;
        gb_data    = 8'h00;
        gb_write_n = 1'b1;
        gb_read_n  = 1'b1;
        cs_n       = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (S + 3) @(negedge clk);
        settled = 1'b1;

        set_bus(4'h4, 1'b0);
        chk("rst_rom_bank", rom_bank, 9'h001);
        chk("rst_ram_bank", ram_bank, 4'h0);
        chk("rst_ram_cs", ram_cs, 1'b0);
        chk("rst_wr_commit", wr_commit, 1'b0);

        c0 = n_commit;
        do_write(4'h2, 8'h5A, 3, 1'b1);
        do_write(4'h3, 8'h01, 3, 1'b0);
        set_bus(4'h4, 1'b1);
        chk("rom_15a_hi", rom_bank, 9'h15A);
        set_bus(4'h0, 1'b1);
        chk("rom_15a_lo", rom_bank, 9'h000);
        chk("rom_two_commits", n_commit - c0, 2);

        do_write(4'h0, 8'h0A, 3, 1'b1);
        set_bus(4'hA, 1'b0);
        chk("ram_cs_enabled", ram_cs, 1'b1);
        do_write(4'h0, 8'h00, 3, 1'b1);
        set_bus(4'hA, 1'b0);
        chk("ram_cs_disabled", ram_cs, 1'b0);

        c0 = n_commit;
        do_write(4'h4, 8'h03, 1, 1'b1);
        chk("glitch_ram_bank", ram_bank, 4'h0);
        chk("glitch_no_commit", n_commit - c0, 0);

        do_write(4'h3, 8'h00, 3, 1'b1);
        do_write(4'h2, 8'h00, 3, 1'b1);
        set_bus(4'h4, 1'b1);
`ifdef MBC_BANK0_REMAP_EN
        chk("bank0_write", rom_bank, 9'h001);
`else
        chk("bank0_write", rom_bank, 9'h000);
`endif

        do_write(4'h4, 8'h05, 2, 1'b1);
        chk("ram_bank_5", ram_bank, 4'h5);

        c0 = n_commit;
        @(negedge clk);
        settled    = 1'b0;
        gb_addr    = 4'h4;
        gb_data    = 8'h02;
        gb_write_n = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        gb_write_n = 1'b1;
        repeat (S + 4) @(negedge clk);
        settled = 1'b1;
        #1;
        chk("armed_reset_ram_bank", ram_bank, 4'h0);
        chk("armed_reset_no_commit", n_commit - c0, 0);

        for (int i = 0; i < 40; i++) begin
            do_write(4'($urandom_range(0, 15)), 8'($urandom),
                     $urandom_range(1, 4), 1'($urandom));
            for (int j = 0; j < 3; j++) begin
                @(negedge clk);
                gb_addr   = 4'($urandom);
                gb_data   = 8'($urandom);
                cs_n      = 1'($urandom);
                gb_read_n = 1'($urandom);
            end
        end

        repeat (3) @(negedge clk);
        chk("commit_count", n_commit, exp_commits);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mbc_sync.md
MBC_SYNC -- requirements
Module: mbc_sync

Interface
REQ-001 SHALL have parameter ROM_BANK_W, default 9, ROM bank register width (legal 2..9).
REQ-002 SHALL have parameter RAM_BANK_W, default 4, RAM bank register width (legal 1..4).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth for cartridge-bus inputs (legal 2..3).
REQ-004 SHALL have parameter MIN_LOW, default 2, minimum synchronised gb_write_n low time in clk cycles for a write to count (legal 1..7).
REQ-005 SHALL have ports: clk in 1, system clock; rst_n in 1, reset.
REQ-006 SHALL have ports: gb_addr in 4, GB address bits [15:12]; gb_data in 8, GB data bus; gb_write_n in 1, write strobe; gb_read_n in 1, read strobe; cs_n in 1, cartridge RAM-area select.
REQ-007 SHALL have ports: rom_bank out ROM_BANK_W, mapped ROM bank; ram_bank out RAM_BANK_W, mapped RAM bank; rom_cs_n out 1; ram_cs out 1; ram_cs_n out 1; wr_commit out 1, one-cycle register-update pulse.
REQ-008 SHALL use one clock, clk; reset rst_n is asynchronous and active-low.

Function
REQ-009 SHALL pass gb_write_n, gb_addr and gb_data through SYNC_STAGES flops before any use in sequential logic.
REQ-010 SHALL implement write-filter FSM IDLE, LOW, ARMED, COMMIT.
REQ-011 IDLE -> LOW when synced gb_write_n = 0; capture synced gb_addr and gb_data; low counter = 1.
REQ-012 LOW: counter increments each cycle while write_n = 0; -> ARMED when counter reaches MIN_LOW; -> IDLE with no update if write_n returns to 1 first (glitch discarded).
REQ-013 ARMED -> COMMIT on synced write_n = 1; COMMIT lasts one cycle, updates the decoded register, asserts wr_commit, then -> IDLE.
REQ-014 Decode of the captured address in COMMIT: 000x -> ram_en = (data[3:0] == 4'hA); 0010 -> rom_bank[7:0] = data (truncated to ROM_BANK_W); 0011 -> rom_bank[8] = data[0] if ROM_BANK_W = 9, else ignored; 010x -> ram_bank = data[RAM_BANK_W-1:0]; 011x and 1xxx -> no register change, wr_commit still asserted.
REQ-015 rom_bank output SHALL equal all-zero while raw gb_addr[14] = 0, else the ROM bank register (combinational on gb_addr[14]).
REQ-016 ram_bank output SHALL equal the RAM bank register at all times.
REQ-017 ram_cs = ~cs_n & ~gb_addr[14] & gb_addr[13] & ram_en; ram_cs_n = ~ram_cs (combinational, unsynchronised).
REQ-018 rom_cs_n = ~((~gb_addr[15] & ~gb_read_n) | ~rst_n) (combinational).
REQ-019 Simultaneous gb_read_n and gb_write_n low: write processed per REQ-011..014; rom_cs_n follows REQ-018 unchanged.
REQ-020 Register updates SHALL occur only in COMMIT; latency from the synced write_n rising edge to the new bank value is 1 clk.

Reset
REQ-021 rst_n low SHALL asynchronously set: FSM IDLE, counter 0, synchroniser flops to 1 (strobes) / 0 (addr, data), ram_en 0, ROM bank register 1, RAM bank register 0, wr_commit 0.
REQ-022 Reset asserted mid-write (LOW, ARMED or COMMIT) SHALL abort the write with no register change after reset release.
REQ-023 After rst_n release, a write with gb_write_n already low SHALL be ignored until write_n is seen high once.

Configuration
REQ-024 Macro MBC_BANK0_REMAP_EN defined: a commit that would make the full ROM bank register 0 SHALL store 1 instead.
REQ-025 Macro MBC_BANK0_REMAP_EN undefined: value 0 SHALL be stored and mapped into 4000-7FFF.

Structure
REQ-026 Package mbc_pkg SHALL hold the FSM state typedef, register-region decode constants, and reset values (ROM bank 1, RAM bank 0).
REQ-027 Sub-module mbc_wr_filter SHALL contain the synchronisers, low counter and FSM, emitting the commit pulse with captured addr/data; mbc_sync holds decode, registers and chip-select logic.

Verification
REQ-028 Reset, then read gb_addr = 4'h4 -> rom_bank = 1, ram_bank = 0, ram_cs = 0, wr_commit = 0.
REQ-029 Write 0x2000 data 0x5A, then 0x3000 data 0x01, with gb_addr[14] = 1 -> rom_bank = 9'h15A; with gb_addr[14] = 0 -> 0; two wr_commit pulses.
REQ-030 Write 0x0000 data 0x0A, cs_n = 0, gb_addr = 4'hA -> ram_cs = 1; write data 0x00 -> ram_cs = 0.
REQ-031 gb_write_n low for 1 synced cycle with MIN_LOW = 2 at 0x4000 data 0x03 -> ram_bank unchanged, no wr_commit.
REQ-032 Write 0x2000 data 0x00 with ROM high bit 0 -> rom_bank = 1 when MBC_BANK0_REMAP_EN is defined, 0 when it is undefined.
REQ-033 rst_n pulsed low while the FSM is in ARMED for a 0x4000 data 0x02 write -> ram_bank = 0 afterwards, no wr_commit.
